// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MEMWAIT  = 2'd1,
    CAUSE_REDIRECT = 2'd2,
    CAUSE_LOADUSE  = 2'd3
  } cause_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load destination and the ID sources.
module hazard_detect (
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is never written, so a load to x0 cannot create a dependency
    hazard  = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC/stage-register enables, flushes, redirects, memory-wait timeout and stall counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_branch_taken,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_jalr_target,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             mem_req,
  input  logic             mem_valid,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  cause_t        cause;
  logic [TW-1:0] wait_cnt;
  logic          mem_wait;
  logic          redirect;
  logic          load_use;

  hazard_detect u_hazard (
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .hazard     (load_use)
  );

  always_comb begin
    mem_wait = mem_req && !mem_valid;
    redirect = ex_branch_taken || ex_jal || ex_jalr;
    cause    = CAUSE_NONE;
    if (mem_wait)      cause = CAUSE_MEMWAIT;
    else if (redirect) cause = CAUSE_REDIRECT;
    else if (load_use) cause = CAUSE_LOADUSE;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    mem_timeout  = 1'b0;
    // Branch/JAL win over JALR; JALR target has bit 0 cleared
    pc_target    = (ex_branch_taken || ex_jal) ? ex_target : (ex_jalr_target & ~32'd1);
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '1;
      pc_target = '0;
    end else if (state == ERR) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      mem_timeout = 1'b1;
    end else begin
      unique case (cause)
        CAUSE_MEMWAIT: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          mem_wb_flush = 1'b1;
        end
        CAUSE_REDIRECT: begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        CAUSE_LOADUSE: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (state != ERR) begin
        if (mem_wait) begin
          state    <= (wait_cnt == WAIT_LAST) ? ERR : MEM_WAIT;
          wait_cnt <= wait_cnt + TW'(1);
        end else begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_branch_taken, ex_jal, ex_jalr;
  logic [31:0] ex_target, ex_jalr_target;
  logic        ex_is_load;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        mem_req, mem_valid;
  logic        pc_en, pc_redirect;
  logic [31:0] pc_target;
  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_target(ex_target), .ex_jalr_target(ex_jalr_target),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .mem_req(mem_req), .mem_valid(mem_valid),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: error flag, consecutive wait cycles, perf counts
  bit m_err;
  int m_waits;
  int m_stall;
  int m_flush;

  bit          e_pc_en, e_if_id_en, e_id_ex_en, e_ex_mem_en, e_mem_wb_en;
  bit          e_if_id_flush, e_id_ex_flush, e_mem_wb_flush, e_redirect, e_timeout;
  logic [31:0] e_target;

  function automatic bit is_load_use();
    return ex_is_load && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_outputs();
    bit waiting, redir;
    waiting = mem_req && !mem_valid;
    redir   = ex_branch_taken || ex_jal || ex_jalr;
    {e_pc_en, e_if_id_en, e_id_ex_en, e_ex_mem_en, e_mem_wb_en} = 5'b11111;
    {e_if_id_flush, e_id_ex_flush, e_mem_wb_flush} = 3'b000;
    e_redirect = 0;
    e_timeout  = 0;
    e_target   = (ex_branch_taken || ex_jal) ? ex_target : {ex_jalr_target[31:1], 1'b0};
    if (rst) begin
      {e_pc_en, e_if_id_en, e_id_ex_en, e_ex_mem_en, e_mem_wb_en} = 5'b00000;
      {e_if_id_flush, e_id_ex_flush, e_mem_wb_flush} = 3'b111;
      e_target = 32'd0;
    end else if (m_err) begin
      {e_pc_en, e_if_id_en, e_id_ex_en, e_ex_mem_en, e_mem_wb_en} = 5'b00000;
      e_timeout = 1;
    end else if (waiting) begin
      {e_pc_en, e_if_id_en, e_id_ex_en, e_ex_mem_en, e_mem_wb_en} = 5'b00000;
      e_mem_wb_flush = 1;
    end else if (redir) begin
      e_redirect = 1;
      e_if_id_flush = 1;
      e_id_ex_flush = 1;
    end else if (is_load_use()) begin
      e_pc_en = 0;
      e_if_id_en = 0;
      e_id_ex_flush = 1;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc_en)  m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (e_redirect) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      if (!m_err) begin
        if (mem_req && !mem_valid) begin
          m_waits++;
          if (m_waits == TO) m_err = 1;
        end else begin
          m_waits = 0;
        end
      end
    end
  endtask

  // Inputs are already applied; check all outputs mid-cycle, then clock
  task automatic cycle();
    #1;
    model_outputs();
    check_eq("pc_en",        pc_en,        e_pc_en);
    check_eq("if_id_en",     if_id_en,     e_if_id_en);
    check_eq("id_ex_en",     id_ex_en,     e_id_ex_en);
    check_eq("ex_mem_en",    ex_mem_en,    e_ex_mem_en);
    check_eq("mem_wb_en",    mem_wb_en,    e_mem_wb_en);
    check_eq("if_id_flush",  if_id_flush,  e_if_id_flush);
    check_eq("id_ex_flush",  id_ex_flush,  e_id_ex_flush);
    check_eq("mem_wb_flush", mem_wb_flush, e_mem_wb_flush);
    check_eq("pc_redirect",  pc_redirect,  e_redirect);
    check_eq("mem_timeout",  mem_timeout,  e_timeout);
    check_eq("stall_cnt",    stall_cnt,    m_stall);
    check_eq("flush_cnt",    flush_cnt,    m_flush);
    if (e_redirect || rst) check_eq("pc_target", pc_target, e_target);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0;
    ex_branch_taken = 0; ex_jal = 0; ex_jalr = 0;
    ex_target = 32'h0; ex_jalr_target = 32'h0;
    ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    mem_req = 0; mem_valid = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1; ex_rd = rd;
    id_rs1 = 5'd5; id_use_rs1 = 1;
    id_rs2 = 5'd1; id_use_rs2 = 1;
  endtask

  int unsigned r;
  int          stall_before;

  initial begin
    idle_inputs();
    rst = 1;
    m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    cycle();
    cycle();
    check_eq("rst_stall_cnt", stall_cnt, 0);
    rst = 0;
    cycle();

    // Load x5 in EX, ID add x6,x5,x1
    set_load_use(5'd5);
    #1 check_eq("lu_pc_en", pc_en, 0);
    cycle();
    idle_inputs();
    #1 check_eq("lu_stall_cnt", stall_cnt, 1);
    cycle();
    set_load_use(5'd0);
    #1 check_eq("lu_x0_pc_en", pc_en, 1);
    cycle();

    // Taken branch
    idle_inputs();
    ex_branch_taken = 1; ex_target = 32'h100;
    #1 check_eq("br_target", pc_target, 32'h100);
    cycle();
    idle_inputs();
    #1 check_eq("br_flush_cnt", flush_cnt, 1);

    // JALR low bit cleared
    ex_jalr = 1; ex_jalr_target = 32'h203; ex_target = 32'h5555;
    #1 check_eq("jalr_target", pc_target, 32'h202);
    cycle();

    // Three-cycle memory wait with a pending branch, release fires redirect
    idle_inputs();
    ex_branch_taken = 1; ex_target = 32'h340;
    mem_req = 1; mem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("wait_pc_en", pc_en, 0);
      cycle();
    end
    mem_valid = 1;
    #1 check_eq("release_redirect", pc_redirect, 1);
    cycle();

    // Branch plus load-use together
    idle_inputs();
    set_load_use(5'd5);
    ex_branch_taken = 1; ex_target = 32'h80;
    stall_before = m_stall;
    cycle();
    idle_inputs();
    #1 check_eq("br_lu_stall_cnt", stall_cnt, stall_before);
    cycle();

    // Timeout after TO wait cycles, cleared by reset
    mem_req = 1; mem_valid = 0;
    for (int i = 0; i < TO; i++) cycle();
    #1 check_eq("err_flag", mem_timeout, 1);
    cycle();
    mem_valid = 1;
    #1 check_eq("err_sticky", mem_timeout, 1);
    cycle();
    rst = 1;
    cycle();
    idle_inputs();
    #1 check_eq("err_cleared", mem_timeout, 0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom;
      rst             = ($urandom_range(0, 99) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_jal          = ($urandom_range(0, 15) == 0);
      ex_jalr         = ($urandom_range(0, 15) == 0);
      ex_target       = $urandom;
      ex_jalr_target  = $urandom;
      ex_is_load      = r[0];
      ex_rd           = 5'($urandom_range(0, 5));
      id_rs1          = 5'($urandom_range(0, 5));
      id_rs2          = 5'($urandom_range(0, 5));
      id_use_rs1      = r[1];
      id_use_rs2      = r[2];
      mem_req         = (r[5:3] < 3'd3);
      mem_valid       = r[6];
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
